// File: rtl/rom_nibble_fetch.sv
// rom_nibble_fetch: reads ROM_WORDS 4-bit words from a synchronous ROM, pairs
// them into 8-bit samples (even word = high nibble) and delivers them through
// a first-word-fall-through FIFO with valid/ready handshake.
// Optional feature macro FETCH_CHECKSUM_EN adds a running 16-bit sum of all
// delivered samples (checksum) and checksum_valid (mirrors done).
module rom_nibble_fetch #(
   parameter int FIFO_DEPTH = 4,
   parameter int ROM_WORDS  = 1024
) (
   input  logic        clk,
   input  logic        reset,
   output logic        rom_cen,
   output logic [9:0]  rom_a,
   input  logic [3:0]  rom_q,
   output logic        x_valid,
   input  logic        x_ready,
   output logic [7:0]  x,
   output logic        done
`ifdef FETCH_CHECKSUM_EN
   ,
   output logic [15:0] checksum,
   output logic        checksum_valid
`endif
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam logic [10:0] LAST = 11'(ROM_WORDS - 1);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [10:0]     nxt_q, nxt_d;        // address of the next read to issue
   logic            rom_cen_q, rom_cen_d;
   logic [9:0]      rom_a_q, rom_a_d;
   logic            vld2_q;              // rom_q carries a requested word this cycle
   logic            par2_q;              // address parity of that word
   logic [3:0]      hold_q;              // high nibble waiting for its partner
   logic [7:0]      mem_q [FIFO_DEPTH];
   logic [PW-1:0]   wr_q, rd_q;
   logic [CW-1:0]   occ_q, occ_d;
   logic [CW-1:0]   infl_q, infl_d;      // samples whose even read is issued but not yet pushed
   logic            push, pop, issue, issue_even, budget_ok;

   assign push    = vld2_q & par2_q;
   assign x_valid = (occ_q != '0);
   assign pop     = x_valid & x_ready;
   assign x       = x_valid ? mem_q[rd_q] : 8'h00;
   assign done    = (state_q == S_DONE);
   assign rom_cen = rom_cen_q;
   assign rom_a   = rom_a_q;

   // Read issue, occupancy bookkeeping and FSM next state
   always_comb begin
      state_d    = state_q;
      budget_ok  = ((CW+1)'(occ_q) + (CW+1)'(infl_q)) < (CW+1)'(FIFO_DEPTH);
      // An odd read always follows its even partner, so only the even read is gated
      issue      = ((state_q == S_IDLE) || (state_q == S_FETCH)) && (nxt_q[0] || budget_ok);
      issue_even = issue & ~nxt_q[0];
      rom_cen_d  = ~issue;
      rom_a_d    = issue ? nxt_q[9:0] : rom_a_q;
      nxt_d      = nxt_q + 11'(issue);
      occ_d      = occ_q + CW'(push) - CW'(pop);
      infl_d     = infl_q + CW'(issue_even) - CW'(push);
      case (state_q)
         S_IDLE:  state_d = S_FETCH;
         S_FETCH: if (issue && (nxt_q == LAST)) state_d = S_DRAIN;
         S_DRAIN: if ((occ_d == '0) && (infl_d == '0)) state_d = S_DONE;
         S_DONE:  state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
   end

   // Control state, ROM port registers and read-return pipeline
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         nxt_q     <= '0;
         rom_cen_q <= 1'b1;
         rom_a_q   <= '0;
         vld2_q    <= 1'b0;
         par2_q    <= 1'b0;
         hold_q    <= '0;
         occ_q     <= '0;
         infl_q    <= '0;
      end else begin
         state_q   <= state_d;
         nxt_q     <= nxt_d;
         rom_cen_q <= rom_cen_d;
         rom_a_q   <= rom_a_d;
         vld2_q    <= ~rom_cen_q;
         par2_q    <= rom_a_q[0];
         if (vld2_q && !par2_q) hold_q <= rom_q;
         occ_q     <= occ_d;
         infl_q    <= infl_d;
      end
   end

   // Sample FIFO storage and pointers (depth is a power of two, pointers wrap)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (push) begin
            mem_q[wr_q] <= {hold_q, rom_q};
            wr_q        <= wr_q + 1'b1;
         end
         if (pop) rd_q <= rd_q + 1'b1;
      end
   end

`ifdef FETCH_CHECKSUM_EN
   logic [15:0] csum_q;
   // Running sum of delivered samples
   always_ff @(posedge clk or posedge reset) begin
      if (reset)    csum_q <= '0;
      else if (pop) csum_q <= csum_q + 16'(x);
   end
   assign checksum       = csum_q;
   assign checksum_valid = done;
`endif

endmodule

// File: tb/tb_rom_nibble_fetch.sv
// Bench for rom_nibble_fetch: a default instance (1024 words) and a small
// ROM_WORDS=8 instance, both fed by a synchronous ROM model. Expected samples
// are built from the ROM contents as {mem[2k], mem[2k+1]}.
module tb_rom_nibble_fetch;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, rom_cen, x_valid, x_ready, done;
   logic [9:0] rom_a;
   logic [3:0] rom_q;
   logic [7:0] x;
   logic       rst8, rom_cen8, x_valid8, x_ready8, done8;
   logic [9:0] rom_a8;
   logic [3:0] rom_q8;
   logic [7:0] x8;
`ifdef FETCH_CHECKSUM_EN
   logic [15:0] checksum, checksum8;
   logic        checksum_valid, checksum_valid8;
`endif

   rom_nibble_fetch dut (
      .clk(clk), .reset(reset), .rom_cen(rom_cen), .rom_a(rom_a), .rom_q(rom_q),
      .x_valid(x_valid), .x_ready(x_ready), .x(x), .done(done)
`ifdef FETCH_CHECKSUM_EN
      , .checksum(checksum), .checksum_valid(checksum_valid)
`endif
   );

   rom_nibble_fetch #(.FIFO_DEPTH(4), .ROM_WORDS(8)) dut8 (
      .clk(clk), .reset(rst8), .rom_cen(rom_cen8), .rom_a(rom_a8), .rom_q(rom_q8),
      .x_valid(x_valid8), .x_ready(x_ready8), .x(x8), .done(done8)
`ifdef FETCH_CHECKSUM_EN
      , .checksum(checksum8), .checksum_valid(checksum_valid8)
`endif
   );

   logic [3:0] mem [1024];
   always @(posedge clk) begin
      if (!rom_cen)  rom_q  <= mem[rom_a];
      if (!rom_cen8) rom_q8 <= mem[rom_a8];
   end

   int          nvec = 0, nerr = 0;
   int          npop;
   logic [7:0]  expq [$];
   logic [15:0] sum_model;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic build_model(input bit incr);
      expq.delete();
      for (int i = 0; i < 1024; i++) mem[i] = incr ? 4'(i) : 4'($urandom);
      for (int k = 0; k < 512; k++) expq.push_back({mem[2*k], mem[2*k+1]});
   endtask

   // Holds reset a few cycles, checks reset values, releases at a falling edge
   task automatic do_reset();
      reset   = 1'b1;
      x_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_rom_cen", 32'(rom_cen), 32'd1);
      chk("rst_rom_a",   32'(rom_a),   32'd0);
      chk("rst_x_valid", 32'(x_valid), 32'd0);
      chk("rst_x",       32'(x),       32'd0);
      chk("rst_done",    32'(done),    32'd0);
      npop      = 0;
      sum_model = '0;
      reset     = 1'b0;
   endtask

   // mode 0: ready held high, 1: toggling, 2: random. Checks every pop in order.
   task automatic stream(input int mode, input int stop_at, input int budget);
      int cyc = 0;
      while (npop < stop_at && cyc < budget) begin
         case (mode)
            0:       x_ready = 1'b1;
            1:       x_ready = (cyc % 2) == 0;
            default: x_ready = 1'($urandom_range(0, 1));
         endcase
         if (x_valid && x_ready) begin
            chk("pop_data", 32'(x), 32'(expq[npop]));
            sum_model = sum_model + 16'(expq[npop]);
            npop++;
         end
         @(negedge clk);
         cyc++;
      end
      if (npop < stop_at) chk("stream_timeout", 32'(npop), 32'(stop_at));
      x_ready = 1'b0;
   endtask

   task automatic chk_done(input string tag);
      chk({tag, "_done"},    32'(done),    32'd1);
      chk({tag, "_rom_cen"}, 32'(rom_cen), 32'd1);
      chk({tag, "_x_valid"}, 32'(x_valid), 32'd0);
      chk({tag, "_last_a"},  32'(rom_a),   32'd1023);
`ifdef FETCH_CHECKSUM_EN
      chk({tag, "_checksum"}, 32'(checksum),       32'(sum_model));
      chk({tag, "_ck_valid"}, 32'(checksum_valid), 32'd1);
`endif
   endtask

   initial begin
      int reads, k8, last8;
      reset = 1'b1; rst8 = 1'b1; x_ready = 1'b0; x_ready8 = 1'b1;
      build_model(1'b1);

      // Small 8-word instance: 4 samples then quiet
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst8 = 1'b0;
      k8 = 0; last8 = -1;
      for (int c = 0; c < 60 && !done8; c++) begin
         @(negedge clk);
         if (!rom_cen8) last8 = int'(rom_a8);
         if (x_valid8) begin
            if (k8 < 4) chk("s8_data", 32'(x8), 32'(expq[k8]));
            k8++;
         end
      end
      chk("s8_count",  32'(k8),    32'd4);
      chk("s8_last_a", 32'(last8), 32'd7);
      chk("s8_done",   32'(done8), 32'd1);
      repeat (5) @(negedge clk);
      chk("s8_cen_idle", 32'(rom_cen8), 32'd1);
      chk("s8_a_hold",   32'(rom_a8),   32'd7);

      // Counting ROM, ready held high: latency and full run
      do_reset();
      x_ready = 1'b1;
      @(negedge clk);  // after E1
      chk("e1_rom_cen", 32'(rom_cen), 32'd0);
      chk("e1_rom_a",   32'(rom_a),   32'd0);
      @(negedge clk);  // after E2
      chk("e2_rom_a",   32'(rom_a),   32'd1);
      @(negedge clk);  // after E3
      chk("e3_x_valid", 32'(x_valid), 32'd0);
      @(negedge clk);  // after E4
      chk("e4_x_valid", 32'(x_valid), 32'd1);
      chk("e4_x",       32'(x),       32'h01);
      stream(0, 512, 1200);
      chk_done("inc");
      chk("inc_checksum_model", 32'(sum_model), 32'hF000);

      // Backpressure from E1: exactly 4 samples (8 reads) buffered
      build_model(1'b0);
      do_reset();
      reads = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (!rom_cen) reads++;
      end
      chk("bp_reads",   32'(reads),   32'd8);
      chk("bp_rom_cen", 32'(rom_cen), 32'd1);
      chk("bp_x_valid", 32'(x_valid), 32'd1);
      chk("bp_x_held",  32'(x),       32'(expq[0]));
      stream(0, 512, 1200);
      chk_done("bp");

      // Ready toggling every cycle
      build_model(1'b0);
      do_reset();
      stream(1, 512, 2400);
      chk_done("tog");

      // Random ready, reset after 100 pops, then full restart
      build_model(1'b0);
      do_reset();
      stream(2, 100, 1000);
      reset = 1'b1;
      #1;
      chk("mid_rst_rom_cen", 32'(rom_cen), 32'd1);
      chk("mid_rst_rom_a",   32'(rom_a),   32'd0);
      chk("mid_rst_x_valid", 32'(x_valid), 32'd0);
      chk("mid_rst_x",       32'(x),       32'd0);
`ifdef FETCH_CHECKSUM_EN
      chk("mid_rst_checksum", 32'(checksum), 32'd0);
`endif
      do_reset();
      @(negedge clk);  // after E1
      chk("restart_rom_a",   32'(rom_a),   32'd0);
      chk("restart_rom_cen", 32'(rom_cen), 32'd0);
      stream(2, 512, 5000);
      chk_done("rnd");

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/rom_nibble_fetch.md
ROM_NIBBLE_FETCH -- requirements
Module: rom_nibble_fetch

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4; output buffer depth in 8-bit samples, power of two, minimum 2.
REQ-002 SHALL have parameter ROM_WORDS, default 1024; number of 4-bit ROM words to read, even, maximum 1024.
REQ-003 SHALL have port clk, input, 1 bit; clock, all state on rising edge.
REQ-004 SHALL have port reset, input, 1 bit; asynchronous, active-high reset.
REQ-005 SHALL have port rom_cen, output, 1 bit; ROM chip enable, active-low, registered.
REQ-006 SHALL have port rom_a, output, 10 bits; ROM word address, registered.
REQ-007 SHALL have port rom_q, input, 4 bits; ROM read data, valid in the cycle after the ROM samples rom_a with rom_cen=0.
REQ-008 SHALL have port x_valid, output, 1 bit; x holds a valid sample.
REQ-009 SHALL have port x_ready, input, 1 bit; consumer accepts x this cycle.
REQ-010 SHALL have port x, output, 8 bits; assembled sample, high nibble first.
REQ-011 SHALL have port done, output, 1 bit; all samples fetched and delivered.

Function
REQ-012 SHALL run the FSM IDLE -> FETCH -> DRAIN -> DONE; IDLE lasts one cycle after reset release.
REQ-013 SHALL drive rom_cen=0 and rom_a=0 from the first rising edge after reset deassertion (edge E1).
REQ-014 SHALL advance rom_a by 1 on each cycle a read is issued; rom_cen=1 on every cycle with no issued read.
REQ-015 SHALL form sample k as {word 2k, word 2k+1}; word 2k is captured into a holding register, and sample k is pushed on the capture of word 2k+1.
REQ-016 SHALL issue the read of an even address only when FIFO occupancy plus samples in flight is less than FIFO_DEPTH, and the read of an odd address unconditionally after its even partner.
REQ-017 SHALL present the FIFO head on x combinationally (first-word fall-through); with x_ready=1 throughout, x_valid first rises at edge E4.
REQ-018 SHALL pop the FIFO on x_valid && x_ready; a push and a pop in the same cycle leave occupancy unchanged.
REQ-019 SHALL hold x stable while x_valid=1 and x_ready=0.
REQ-020 SHALL sustain one sample per 2 cycles with x_ready held at 1.
REQ-021 SHALL move FETCH -> DRAIN after issuing address ROM_WORDS-1, with no wrap to 0.
REQ-022 SHALL move DRAIN -> DONE once the last sample is popped and the FIFO is empty.
REQ-023 SHALL hold done=1, rom_cen=1 and x_valid=0 in DONE until reset.
REQ-024 SHALL never overflow the FIFO and never assert x_valid while the FIFO is empty.

Reset
REQ-025 SHALL on reset set rom_cen=1, rom_a=0, x_valid=0, x=0, done=0, FIFO empty, holding register 0, FSM=IDLE.
REQ-026 SHALL, on reset asserted mid-operation, discard buffered and in-flight data and restart from address 0 after release.

Configuration
REQ-027 SHALL, with macro FETCH_CHECKSUM_EN defined, add outputs checksum[15:0] and checksum_valid.
REQ-028 With FETCH_CHECKSUM_EN defined, checksum SHALL be the sum modulo 2^16 of all popped samples, reset to 0, and checksum_valid SHALL equal done.
REQ-029 With FETCH_CHECKSUM_EN undefined, the checksum ports and logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-030 ROM model mem[i]=i[3:0], x_ready=1 -> x sequence 0x01,0x23,...,0xEF, repeating, 512 samples; first x_valid at E4; done after the 512th pop.
REQ-031 x_ready=0 from E1 -> exactly FIFO_DEPTH=4 samples buffered, rom_cen stays 1 afterwards, x held at 0x01; on releasing x_ready, order is intact with no loss or duplicate.
REQ-032 x_ready toggling 1/0 every cycle -> 512 samples delivered in order, no overflow, done=1 at the end.
REQ-033 Reset pulse after 100 samples popped -> outputs return to reset values; after release, rom_a restarts at 0 and the first x=0x01.
REQ-034 FETCH_CHECKSUM_EN defined, ROM as REQ-030 -> checksum=0xF000 with checksum_valid=1 when done=1.
REQ-035 ROM_WORDS=8 -> 4 samples 0x01,0x23,0x45,0x67; last rom_a=7; done=1; rom_cen=1 thereafter.
